// File: rtl/hamming_decoder_pipe.sv
// hamming_decoder_pipe
//   Two-stage pipelined SECDED (8,4) decoder with valid/ready handshaking
//   and saturating error counters.
//
//   Codeword layout (bit7..bit0): {p, d3, d2, d1, c2, d0, c1, c0}.
//   Stage 1 captures the data bits, the 3-bit syndrome and the overall
//   parity of the incoming word. Stage 2 applies the correction and
//   registers the decoded data plus error flags.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous active-high reset
//   in_valid    : code_in holds a codeword
//   in_ready    : block accepts code_in this cycle
//   code_in     : 8-bit SECDED codeword
//   out_valid   : data_out / flags / syndrome are valid
//   out_ready   : downstream accepts the output
//   data_out    : corrected data {d3, d2, d1, d0}
//   err_corr    : single-bit error corrected (data or parity bit)
//   err_uncorr  : double-bit error detected, data_out is raw data
//   syndrome    : {s2, s1, s0} for the presented word
//   clear_cnt   : synchronous clear of both counters (wins over increment)
//   corr_cnt    : saturating count of corrected words
//   uncorr_cnt  : saturating count of uncorrectable words
module hamming_decoder_pipe #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [2:0]       syndrome,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef enum logic [1:0] {
    CLS_CLEAN,      // s == 0, p == 0
    CLS_SINGLE,     // s != 0, p == 1 : flip bit (s-1)
    CLS_PARITY,     // s == 0, p == 1 : overall parity bit itself in error
    CLS_DOUBLE      // s != 0, p == 0 : uncorrectable
  } err_cls_t;

  // ---------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------
  logic v1;
  logic v2;
  logic advance2;

  assign advance2  = !v2 || out_ready;
  assign in_ready  = !v1 || advance2;
  assign out_valid = v2;

  // ---------------------------------------------------------------------
  // Stage 1: syndrome and overall parity of the incoming word
  // ---------------------------------------------------------------------
  logic [2:0] syn_in;
  logic       par_in;
  logic [3:0] data_in;

  always_comb begin
    syn_in[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    syn_in[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    syn_in[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];
    par_in    = ^code_in;
    data_in   = {code_in[6], code_in[5], code_in[4], code_in[2]};
  end

  // Only the data bits are kept from the codeword: the check and parity
  // bits are fully summarised by syndrome and parity, so the decode in
  // stage 2 is identical to correcting the whole word and then extracting.
  logic [3:0] data1;
  logic [2:0] syn1;
  logic       par1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      data1 <= '0;
      syn1  <= '0;
      par1  <= 1'b0;
    end else if (in_ready) begin
      // in_ready with v1 set implies stage 2 is taking the current word,
      // so reloading v1 from in_valid never drops a word.
      v1 <= in_valid;
      if (in_valid) begin
        data1 <= data_in;
        syn1  <= syn_in;
        par1  <= par_in;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 decode: classify and correct
  // ---------------------------------------------------------------------
  err_cls_t   cls;
  logic [3:0] flip;
  logic [3:0] data_fix;
  logic       corr_next;
  logic       uncorr_next;

  always_comb begin
    cls = CLS_CLEAN;
    if (syn1 != 3'd0) begin
      cls = par1 ? CLS_SINGLE : CLS_DOUBLE;
    end else if (par1) begin
      cls = CLS_PARITY;
    end
  end

  // Syndrome s points at codeword bit (s-1); only data positions matter
  // here: bit2 (s=3) -> d0, bit4 (s=5) -> d1, bit5 (s=6) -> d2,
  // bit6 (s=7) -> d3. Errors on check bits need no data change.
  always_comb begin
    flip = '0;
    if (cls == CLS_SINGLE) begin
      unique case (syn1)
        3'd3:    flip[0] = 1'b1;
        3'd5:    flip[1] = 1'b1;
        3'd6:    flip[2] = 1'b1;
        3'd7:    flip[3] = 1'b1;
        default: flip    = '0;
      endcase
    end
  end

  always_comb begin
    data_fix    = data1 ^ flip;
    corr_next   = (cls == CLS_SINGLE) || (cls == CLS_PARITY);
    uncorr_next = (cls == CLS_DOUBLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2         <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= '0;
    end else if (advance2) begin
      v2 <= v1;
      if (v1) begin
        data_out   <= data_fix;
        err_corr   <= corr_next;
        err_uncorr <= uncorr_next;
        syndrome   <= syn1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturating error counters, advanced only on an output handshake
  // ---------------------------------------------------------------------
  logic out_hs;

  assign out_hs = v2 && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clear_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_hs) begin
      if (err_corr && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (err_uncorr && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hamming_decoder_pipe.md
HAMMING_DECODER_PIPE -- requirements
Module: hamming_decoder_pipe

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each error counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  code_in holds a codeword.
REQ-005 SHALL have port: in_ready  output  1  block accepts code_in this cycle.
REQ-006 SHALL have port: code_in  input  8  SECDED codeword {p, d3, d2, d1, c2, d0, c1, c0} (bit7..bit0).
REQ-007 SHALL have port: out_valid  output  1  data_out and the flags are valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the output.
REQ-009 SHALL have port: data_out  output  4  decoded (corrected) data {d3, d2, d1, d0}.
REQ-010 SHALL have port: err_corr  output  1  single-bit error corrected in this word.
REQ-011 SHALL have port: err_uncorr  output  1  double-bit error detected; data_out is uncorrected raw data.
REQ-012 SHALL have port: syndrome  output  3  {s2, s1, s0} for this word.
REQ-013 SHALL have port: clear_cnt  input  1  synchronous clear of both counters.
REQ-014 SHALL have port: corr_cnt  output  CNT_W  count of corrected words.
REQ-015 SHALL have port: uncorr_cnt  output  CNT_W  count of uncorrectable words.

Function
REQ-016 SHALL compute s0 = b0^b2^b4^b6, s1 = b1^b2^b5^b6, s2 = b3^b4^b5^b6, and overall parity p = XOR of b7..b0.
REQ-017 SHALL classify each word: s=0, p=0 -> clean; s!=0, p=1 -> flip bit (s-1), err_corr=1; s=0, p=1 -> bit7 error, data unaffected, err_corr=1; s!=0, p=0 -> err_uncorr=1, no flip.
REQ-018 SHALL extract data_out from bits {6, 5, 4, 2} of the corrected word.
REQ-019 SHALL implement two pipeline stages: stage 1 registers code_in, s and p; stage 2 registers the corrected data and the flags.
REQ-020 SHALL have a latency of 2 cycles from the input handshake to out_valid when out_ready=1, and SHALL sustain 1 word per cycle.
REQ-021 SHALL define advance2 = !v2 | out_ready and in_ready = !v1 | advance2, where v1 and v2 are the stage valid bits.
REQ-022 SHALL hold all stage-2 outputs stable while out_valid=1 and out_ready=0.
REQ-023 SHALL never drop or duplicate a word under any in_valid/out_ready pattern.
REQ-024 SHALL update each counter only on an output handshake (out_valid & out_ready): corr_cnt +1 if err_corr, uncorr_cnt +1 if err_uncorr.
REQ-025 SHALL saturate both counters at 2^CNT_W-1, with no wrap-around.
REQ-026 SHALL let clear_cnt win over a simultaneous increment, leaving the counter at 0 on the next cycle.
REQ-027 SHALL have clear_cnt leave the pipeline contents and handshake state unaffected.
REQ-028 SHALL keep in_ready combinational from out_ready and the valid bits only, with no dependence on in_valid.

Reset
REQ-029 SHALL, while rst=1, asynchronously clear v1, v2, data_out, err_corr, err_uncorr, syndrome, corr_cnt and uncorr_cnt to 0.
REQ-030 SHALL drive in_ready=1 during reset.
REQ-031 SHALL discard words in flight when reset is asserted mid-operation, with no output handshake produced for them.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-033 SHALL verify the clean word: code_in=8'h55 -> 2 cycles later data_out=4'hB, err_corr=0, err_uncorr=0, syndrome=0.
REQ-034 SHALL verify a data-bit error: code_in=8'h45 (bit4 flipped) -> data_out=4'hB, err_corr=1, syndrome=3'd5, corr_cnt +1.
REQ-035 SHALL verify a parity-bit error: code_in=8'hD5 (bit7 flipped) -> data_out=4'hB, err_corr=1, syndrome=0.
REQ-036 SHALL verify a double error: code_in=8'h56 (bits 0 and 1 flipped) -> err_uncorr=1, err_corr=0, syndrome=3'd3, uncorr_cnt +1.
REQ-037 SHALL verify backpressure: stream 8 words with out_ready low for 3 cycles mid-stream -> in_ready=0 while both stages are full, outputs held, all 8 words delivered in order.
REQ-038 SHALL verify saturation and reset: CNT_W=2 with 5 corrected words -> corr_cnt=3; then clear_cnt coincident with a corrected handshake -> corr_cnt=0; rst mid-stream -> out_valid=0 immediately.
